// File: rtl/mips_display_pkg.sv
// rtl/mips_display_pkg.sv - shared types, constants and hex7 table for the seven-segment scanner
// Contents: NUM_DIGITS, seg_t/an_t, SEG_OFF/AN_OFF, slot_state_t, HEX7_TABLE (active-low gfedcba).
package mips_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] an_t;

  localparam seg_t SEG_OFF = 7'b1111111;
  localparam an_t  AN_OFF  = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_state_t;

  // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - display bundle between the value source and the scanner
// Signals: value[15:0] (source -> scanner), an[3:0] and seg[6:0] (scanner -> board pins).
// Modports: master = value source / observer, slave = sevenseg_scan.
interface sevenseg_scan_if;
  import mips_display_pkg::*;

  logic [15:0] value;
  an_t         an;
  seg_t        seg;

  modport master (output value, input an, input seg);
  modport slave  (input value, output an, output seg);
endinterface

// File: rtl/hex_to_sevenseg.sv
// rtl/hex_to_sevenseg.sv - combinational nibble to active-low seven-segment decoder
// Ports: nibble[3:0] in, seg[6:0] out ({g,f,e,d,c,b,a}, active-low).
module hex_to_sevenseg
  import mips_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - 4-digit multiplexed common-anode display scanner with per-frame snapshot
// Ports: clk, reset_n (async active-low), disp (sevenseg_scan_if.slave: value in, an/seg out).
// Parameters: REFRESH_DIV (cycles per digit slot, >= 2), BLANK_CYC (blank cycles at slot start, < REFRESH_DIV).
// Optional macro SEVSEG_LZB_EN: leading-zero blanking of digits 3..1.
module sevenseg_scan
  import mips_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic           clk,
  input  logic           reset_n,
  sevenseg_scan_if.slave disp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam slot_state_t RESET_STATE = (BLANK_CYC == 0) ? DRIVE : BLANK;

  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [15:0]   frame, frame_n;
  slot_state_t   state, state_n;
  an_t           an_n;
  seg_t          seg_n;

  logic          slot_end;
  logic [15:0]   frame_shift;
  seg_t          seg_dec;
  logic          lz_blank;

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));

  // Shifting the next frame right by the next digit's nibble offset gives
  // that digit in the low nibble and, above it, every more significant digit.
  assign frame_shift = frame_n >> {idx_n, 2'b00};

  hex_to_sevenseg u_hex (
    .nibble (frame_shift[3:0]),
    .seg    (seg_dec)
  );

`ifdef SEVSEG_LZB_EN
  // Digit blanked when it and all more significant digits are zero; digit 0 always shows.
  assign lz_blank = (idx_n != '0) && (frame_shift == 16'h0000);
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      idx       <= '0;
      frame     <= 16'h0000;
      state     <= RESET_STATE;
      disp.an   <= AN_OFF;
      disp.seg  <= SEG_OFF;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      frame     <= frame_n;
      state     <= state_n;
      disp.an   <= an_n;
      disp.seg  <= seg_n;
    end
  end

  // Outputs are decoded from next-state values so the registered an/seg line
  // up with the registered (cnt, idx, frame) in the same cycle.
  always_comb begin
    cnt_n   = slot_end ? '0 : cnt + 1'b1;
    idx_n   = slot_end ? idx + 1'b1 : idx;
    // Snapshot only at the end of the last slot so a frame never tears.
    frame_n = (slot_end && idx == IW'(NUM_DIGITS - 1)) ? disp.value : frame;

    state_n = state;
    if (cnt_n == '0) begin
      state_n = RESET_STATE;
    end else if (int'(cnt_n) == BLANK_CYC) begin
      state_n = DRIVE;
    end

    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    if (state_n == DRIVE && !lz_blank) begin
      an_n  = ~(an_t'(1) << idx_n);
      seg_n = seg_dec;
    end
  end

endmodule
